seq_fib: RTL and testbench

SEQ_FIB -- requirements
Module: seq_fib

---
 rtl/fib_pkg.sv | 32 +++
 rtl/fib_step.sv | 14 +
 rtl/seq_fib.sv | 114 +++++++++++
 tb/tb_seq_fib.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci/Lucas sequencer.
package fib_pkg;

  // Controller states: waiting for a request, or iterating.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Sequence selection as sampled from the mode input.
  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_LUC = 1'b1;

  // Seeds need only two bits; they are zero-extended into the datapath.
  localparam int unsigned SEED_W = 2;

  localparam logic [SEED_W-1:0] FIB_SEED0 = 2'd0;
  localparam logic [SEED_W-1:0] FIB_SEED1 = 2'd1;
  localparam logic [SEED_W-1:0] LUC_SEED0 = 2'd2;
  localparam logic [SEED_W-1:0] LUC_SEED1 = 2'd1;

  // Term 0 of the selected sequence.
  function automatic logic [SEED_W-1:0] seed0(input logic mode);
    return (mode == MODE_LUC) ? LUC_SEED0 : FIB_SEED0;
  endfunction

  // Term 1 of the selected sequence.
  function automatic logic [SEED_W-1:0] seed1(input logic mode);
    return (mode == MODE_LUC) ? LUC_SEED1 : FIB_SEED1;
  endfunction

endpackage

// File: rtl/fib_step.sv
// One recurrence step: WIDTH-bit sum of the two previous terms plus carry-out.
module fib_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // Widen by one bit so the carry falls out of the same adder.
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/seq_fib.sv
// Iterative n-th term of the Fibonacci or Lucas sequence, one step per clock.
module seq_fib
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NW-1:0]    n,
  input  logic             mode,
  input  logic             abort,
  output logic             ready,
  output logic [WIDTH-1:0] res,
  output logic             valid,
  output logic             ovf
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] sum;
  logic             carry;

  // Single shared adder for the a+b recurrence.
  fib_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i     (a_q),
    .b_i     (b_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath control; abort outranks completion in CALC.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = WIDTH'(seed0(mode));
          b_d     = WIDTH'(seed1(mode));
          cnt_d   = n;
          cy_d    = 1'b0;
          state_d = CALC;
        end
      end

      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q >= NW'(2)) begin
          a_d   = b_q;
          b_d   = sum;
          cy_d  = cy_q | carry;
          cnt_d = cnt_q - NW'(1);
        end else begin
          res_d   = (cnt_q == '0) ? a_q : b_q;
          ovf_d   = cy_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign res   = res_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_fib.sv
// Self-checking bench: 32-bit and 8-bit instances driven in lockstep.
module tb_seq_fib;

  localparam int unsigned NW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [NW-1:0] n;
  logic          mode;
  logic          abort;

  logic          ready32, valid32, ovf32;
  logic [31:0]   res32;
  logic          ready8, valid8, ovf8;
  logic [7:0]    res8;

  int unsigned   n_checks = 0;
  int unsigned   n_fails  = 0;

  logic [31:0]   last_res32;
  logic          last_ovf32;
  logic [7:0]    last_res8;
  logic          last_ovf8;

  seq_fib #(.WIDTH(32), .NW(NW)) u_dut32 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .n     (n),
    .mode  (mode),
    .abort (abort),
    .ready (ready32),
    .res   (res32),
    .valid (valid32),
    .ovf   (ovf32)
  );

  seq_fib #(.WIDTH(8), .NW(NW)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .n     (n),
    .mode  (mode),
    .abort (abort),
    .ready (ready8),
    .res   (res8),
    .valid (valid8),
    .ovf   (ovf8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Exact (unbounded up to 64 bits) n-th term of the chosen sequence.
  function automatic logic [63:0] ref_term(input int unsigned nn, input logic md);
    logic [63:0] x, y, t;
    x = md ? 64'd2 : 64'd0;
    y = 64'd1;
    if (nn == 0) return x;
    for (int unsigned k = 2; k <= nn; k++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return y;
  endfunction

  // Present a request at #1 after an edge; returns #1 after the accepting edge.
  task automatic accept(input int unsigned nn, input logic md, input logic ab);
    start = 1'b1;
    n     = NW'(nn);
    mode  = md;
    abort = ab;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("ready_busy", 64'(ready32), 64'd0);
    check("valid_at_accept", 64'(valid32), 64'd0);
    check("res_held_at_accept", 64'(res32), 64'(last_res32));
  endtask

  // Wait for the valid pulse; optionally toggle start/n/mode while busy.
  task automatic finish_check(input string tag, input int unsigned nn, input logic noise,
                              input logic [31:0] e32, input logic eo32,
                              input logic [7:0] e8, input logic eo8);
    int unsigned lat;
    bit          seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      @(posedge clk); #1;
      if (valid32) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        check({tag, "_ready_calc"}, 64'(ready32), 64'd0);
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          n     = NW'($urandom_range(0, 90));
          mode  = 1'($urandom_range(0, 1));
        end
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'((nn == 0) ? 1 : nn));
    check({tag, "_res32"}, 64'(res32), 64'(e32));
    check({tag, "_ovf32"}, 64'(ovf32), 64'(eo32));
    check({tag, "_valid8"}, 64'(valid8), 64'd1);
    check({tag, "_res8"}, 64'(res8), 64'(e8));
    check({tag, "_ovf8"}, 64'(ovf8), 64'(eo8));
    check({tag, "_ready_valid"}, 64'(ready32), 64'd1);
    last_res32 = e32;
    last_ovf32 = eo32;
    last_res8  = e8;
    last_ovf8  = eo8;
  endtask

  // One quiet cycle after a completion: the pulse must be gone.
  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 64'(valid32), 64'd0);
    check({tag, "_ready_idle"}, 64'(ready32), 64'd1);
  endtask

  task automatic directed(input string tag, input int unsigned nn, input logic md,
                          input logic [31:0] e32, input logic eo32,
                          input logic [7:0] e8, input logic eo8);
    accept(nn, md, 1'b0);
    finish_check(tag, nn, 1'b0, e32, eo32, e8, eo8);
    idle_check(tag);
  endtask

  initial begin
    logic [63:0] term;
    int unsigned nn;
    logic        md;
    logic        o32, o8;

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 1'b0;
    n     = '0;
    last_res32 = '0;
    last_ovf32 = 1'b0;
    last_res8  = '0;
    last_ovf8  = 1'b0;

    #1;
    check("rst_ready", 64'(ready32), 64'd1);
    check("rst_valid", 64'(valid32), 64'd0);
    check("rst_res32", 64'(res32), 64'd0);
    check("rst_ovf32", 64'(ovf32), 64'd0);
    check("rst_res8", 64'(res8), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    directed("fib0",  0,  1'b0, 32'd0,          1'b0, 8'd0,   1'b0);
    directed("fib1",  1,  1'b0, 32'd1,          1'b0, 8'd1,   1'b0);
    directed("fib10", 10, 1'b0, 32'd55,         1'b0, 8'd55,  1'b0);
    directed("luc10", 10, 1'b1, 32'd123,        1'b0, 8'd123, 1'b0);
    directed("luc0",  0,  1'b1, 32'd2,          1'b0, 8'd2,   1'b0);
    directed("fib47", 47, 1'b0, 32'd2971215073, 1'b0, 8'd225, 1'b1);
    directed("fib48", 48, 1'b0, 32'd512559680,  1'b1, 8'd64,  1'b1);
    directed("fib13", 13, 1'b0, 32'd233,        1'b0, 8'd233, 1'b0);
    directed("fib14", 14, 1'b0, 32'd377,        1'b0, 8'd121, 1'b1);

    // Abort on the fifth edge of a 20-step run, with start held high meanwhile.
    accept(20, 1'b0, 1'b0);
    start = 1'b1;
    n     = NW'(3);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check("held_start_busy", 64'(ready32), 64'd0);
      check("held_start_novalid", 64'(valid32), 64'd0);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check("abort_ready", 64'(ready32), 64'd1);
    check("abort_valid", 64'(valid32), 64'd0);
    check("abort_res32", 64'(res32), 64'(last_res32));
    check("abort_ovf32", 64'(ovf32), 64'(last_ovf32));
    check("abort_res8", 64'(res8), 64'(last_res8));
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      check("abort_no_late_valid", 64'(valid32), 64'd0);
    end

    // Start together with abort in IDLE is still accepted.
    accept(5, 1'b1, 1'b1);
    finish_check("luc5_abort_idle", 5, 1'b0, 32'd11, 1'b0, 8'd11, 1'b0);
    idle_check("luc5_abort_idle");

    // Back-to-back: second request issued in the valid cycle of the first.
    accept(3, 1'b0, 1'b0);
    finish_check("b2b_fib3", 3, 1'b0, 32'd2, 1'b0, 8'd2, 1'b0);
    accept(4, 1'b0, 1'b0);
    finish_check("b2b_fib4", 4, 1'b0, 32'd3, 1'b0, 8'd3, 1'b0);
    idle_check("b2b_fib4");

    // Reset mid-run clears the result without a pulse.
    accept(15, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_res32", 64'(res32), 64'd0);
    check("midrst_valid", 64'(valid32), 64'd0);
    check("midrst_ready", 64'(ready32), 64'd1);
    @(posedge clk); #1;
    check("midrst_hold_valid", 64'(valid32), 64'd0);
    rst = 1'b0;
    last_res32 = '0;
    last_ovf32 = 1'b0;
    last_res8  = '0;
    last_ovf8  = 1'b0;
    accept(2, 1'b1, 1'b0);
    finish_check("post_rst_luc2", 2, 1'b0, 32'd3, 1'b0, 8'd3, 1'b0);
    idle_check("post_rst_luc2");

    // Random requests against the exact-arithmetic model.
    for (int it = 0; it < 30; it++) begin
      nn   = $urandom_range(0, 90);
      md   = 1'($urandom_range(0, 1));
      term = ref_term(nn, md);
      o32  = (nn >= 2) && (term[63:32] != '0);
      o8   = (nn >= 2) && (term[63:8] != '0);
      accept(nn, md, 1'b0);
      finish_check("rand", nn, 1'($urandom_range(0, 1)), term[31:0], o32, term[7:0], o8);
      if ($urandom_range(0, 1) == 0) idle_check("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
